// File: rtl/operand_fetch_stage_if.sv
// Decode-to-execute operand fetch bundle: decode handshake, register file
// read/writeback, and execute handshake for operand_fetch_stage.
interface operand_fetch_stage_if #(
    parameter int WORD_SIZE = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [4:0]           in_rs1;
    logic [4:0]           in_rs2;
    logic [4:0]           in_rd;
    logic                 in_writes;
    logic [4:0]           rf_rs1;
    logic [4:0]           rf_rs2;
    logic [WORD_SIZE-1:0] rf_rv1;
    logic [WORD_SIZE-1:0] rf_rv2;
    logic                 wb_en;
    logic [4:0]           wb_rd;
    logic [WORD_SIZE-1:0] wb_data;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [WORD_SIZE-1:0] out_rv1;
    logic [WORD_SIZE-1:0] out_rv2;
    logic [4:0]           out_rd;
    logic                 out_writes;
    logic [31:0]          stall_count;

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_writes,
        input  rf_rv1, rf_rv2,
        input  wb_en, wb_rd, wb_data,
        input  flush, out_ready,
        output in_ready, rf_rs1, rf_rs2,
        output out_valid, out_rv1, out_rv2, out_rd, out_writes,
        output stall_count
    );

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_writes,
        output rf_rv1, rf_rv2,
        output wb_en, wb_rd, wb_data,
        output flush, out_ready,
        input  in_ready, rf_rs1, rf_rs2,
        input  out_valid, out_rv1, out_rv2, out_rd, out_writes,
        input  stall_count
    );
endinterface

// File: rtl/operand_fetch_stage.sv
// Operand fetch with writeback bypass and 32-entry write scoreboard.
// Define OPFETCH_STALL_COUNTER_EN to build the saturating hazard stall counter.
module operand_fetch_stage #(
    parameter int WORD_SIZE = 32
) (
    input logic                  clk,
    input logic                  rst,
    operand_fetch_stage_if.slave bus
);
    logic [31:0]          busy;
    logic [31:0]          busy_n;
    logic                 hazard;
    logic                 accept;
    logic                 consume;
    logic                 drop;
    logic [WORD_SIZE-1:0] op1;
    logic [WORD_SIZE-1:0] op2;

    logic                 valid_q;
    logic [WORD_SIZE-1:0] rv1_q;
    logic [WORD_SIZE-1:0] rv2_q;
    logic [4:0]           rd_q;
    logic                 writes_q;

    // A register retiring this cycle no longer blocks issue.
    function automatic logic busy_eff(
        input logic [31:0] b,
        input logic [4:0]  r,
        input logic        we,
        input logic [4:0]  wr
    );
        return b[r] && !(we && wr == r);
    endfunction

    always_comb begin
        hazard = 1'b0;
        if (bus.in_valid) begin
            hazard = (bus.in_rs1 != 5'd0 &&
                      busy_eff(busy, bus.in_rs1, bus.wb_en, bus.wb_rd)) ||
                     (bus.in_rs2 != 5'd0 &&
                      busy_eff(busy, bus.in_rs2, bus.wb_en, bus.wb_rd)) ||
                     (bus.in_writes && bus.in_rd != 5'd0 &&
                      busy_eff(busy, bus.in_rd, bus.wb_en, bus.wb_rd));
        end
    end

    assign bus.rf_rs1   = bus.in_rs1;
    assign bus.rf_rs2   = bus.in_rs2;
    assign bus.in_ready = (!valid_q || bus.out_ready) && !hazard && !bus.flush;

    assign accept  = bus.in_valid && bus.in_ready;
    assign consume = valid_q && bus.out_ready;
    assign drop    = bus.flush && valid_q && writes_q && rd_q != 5'd0;

    always_comb begin
        op1 = '0;
        op2 = '0;
        if (bus.in_rs1 == 5'd0)
            op1 = '0;
        else if (bus.wb_en && bus.wb_rd == bus.in_rs1)
            op1 = bus.wb_data;
        else
            op1 = bus.rf_rv1;
        if (bus.in_rs2 == 5'd0)
            op2 = '0;
        else if (bus.wb_en && bus.wb_rd == bus.in_rs2)
            op2 = bus.wb_data;
        else
            op2 = bus.rf_rv2;
    end

    // Set is applied last so it wins over a same-cycle clear.
    always_comb begin
        busy_n = busy;
        if (bus.wb_en && bus.wb_rd != 5'd0)
            busy_n[bus.wb_rd] = 1'b0;
        if (drop)
            busy_n[rd_q] = 1'b0;
        if (accept && bus.in_writes && bus.in_rd != 5'd0)
            busy_n[bus.in_rd] = 1'b1;
        busy_n[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q  <= 1'b0;
            rv1_q    <= '0;
            rv2_q    <= '0;
            rd_q     <= 5'd0;
            writes_q <= 1'b0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            rv1_q    <= op1;
            rv2_q    <= op2;
            rd_q     <= bus.in_rd;
            writes_q <= bus.in_writes;
        end else if (consume) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid  = valid_q;
    assign bus.out_rv1    = rv1_q;
    assign bus.out_rv2    = rv2_q;
    assign bus.out_rd     = rd_q;
    assign bus.out_writes = writes_q;

`ifdef OPFETCH_STALL_COUNTER_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_q <= '0;
        else if (hazard && stall_q != 32'hFFFF_FFFF)
            stall_q <= stall_q + 32'd1;
    end

    assign bus.stall_count = stall_q;
`else
    assign bus.stall_count = '0;
`endif
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Self-checking bench for operand_fetch_stage: vector table plus
// hand sequences for backpressure, flush and asynchronous reset.
module tb_operand_fetch_stage;
    typedef struct {
        logic        v;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        w;
        logic [31:0] rv1;
        logic [31:0] rv2;
        logic        wbe;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        rdy;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    typedef struct {
        logic [31:0] rv1;
        logic [31:0] rv2;
        logic [4:0]  rd;
        logic        w;
    } exp_t;

    logic clk;
    logic clk_en;
    logic rst;
    int   checks;
    int   errors;
    int   exp_stalls;
    exp_t q[$];
    vec_t vecs[15];

    operand_fetch_stage_if #(.WORD_SIZE(32)) bus ();

    operand_fetch_stage #(.WORD_SIZE(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = clk_en ? ~clk : clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic v, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd,
                          input logic w, input logic [31:0] rv1,
                          input logic [31:0] rv2);
        bus.in_valid  = v;
        bus.in_rs1    = rs1;
        bus.in_rs2    = rs2;
        bus.in_rd     = rd;
        bus.in_writes = w;
        bus.rf_rv1    = rv1;
        bus.rf_rv2    = rv2;
    endtask

    task automatic set_wb(input logic en, input logic [4:0] rd,
                          input logic [31:0] d);
        bus.wb_en   = en;
        bus.wb_rd   = rd;
        bus.wb_data = d;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic w);
        exp_t e;
        e.rv1 = a;
        e.rv2 = b;
        e.rd  = rd;
        e.w   = w;
        q.push_back(e);
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Output side of the scoreboard: compare on transfer, discard on flush.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && (bus.flush || bus.out_ready)) begin
            if (q.size() == 0) begin
                chk("queue_underflow", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                if (!bus.flush) begin
                    chk("out_rv1", bus.out_rv1, e.rv1);
                    chk("out_rv2", bus.out_rv2, e.rv2);
                    chk("out_rd", {27'd0, bus.out_rd}, {27'd0, e.rd});
                    chk("out_writes", {31'd0, bus.out_writes}, {31'd0, e.w});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        exp_stalls = 0;
        clk        = 1'b0;
        clk_en     = 1'b0;
        rst        = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0);
        set_wb(0, 0, 0);

        vecs[0]  = '{1, 3, 4, 1, 0, 'h11, 'h22, 0, 0, 0, 1, 'h11, 'h22};
        vecs[1]  = '{1, 0, 0, 5, 1, 'hFFFFFFFF, 'hFFFFFFFF, 0, 0, 0, 1, 0, 0};
        vecs[2]  = '{1, 5, 2, 6, 0, 'h55, 'h66, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{1, 5, 2, 6, 0, 'h55, 'h66, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{1, 5, 2, 6, 0, 'h55, 'h66, 1, 5, 'hDEAD, 1, 'hDEAD, 'h66};
        vecs[5]  = '{1, 5, 5, 2, 0, 'h77, 'h88, 0, 0, 0, 1, 'h77, 'h88};
        vecs[6]  = '{1, 1, 2, 0, 1, 1, 2, 0, 0, 0, 1, 1, 2};
        vecs[7]  = '{1, 0, 0, 0, 1, 9, 9, 0, 0, 0, 1, 0, 0};
        vecs[8]  = '{1, 1, 1, 8, 1, 3, 3, 0, 0, 0, 1, 3, 3};
        vecs[9]  = '{1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[10] = '{1, 0, 0, 8, 1, 0, 0, 1, 0, 'h99, 0, 0, 0};
        vecs[11] = '{1, 8, 0, 8, 1, 'h44, 'h45, 1, 8, 'hAB, 1, 'hAB, 0};
        vecs[12] = '{1, 8, 0, 9, 0, 'h44, 0, 0, 0, 0, 0, 0, 0};
        vecs[13] = '{1, 0, 8, 9, 0, 0, 'h46, 1, 8, 'hCD, 1, 0, 'hCD};
        vecs[14] = '{0, 1, 2, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0};

        #3;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_stall_count", bus.stall_count, 32'd0);
        chk("rst_out_rv1", bus.out_rv1, 32'd0);
        #1;
        rst    = 1'b0;
        clk_en = 1'b1;
        next();

        foreach (vecs[i]) begin
            set_in(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                   vecs[i].w, vecs[i].rv1, vecs[i].rv2);
            set_wb(vecs[i].wbe, vecs[i].wbrd, vecs[i].wbd);
            @(negedge clk);
            chk($sformatf("in_ready[%0d]", i), {31'd0, bus.in_ready},
                {31'd0, vecs[i].rdy});
            chk($sformatf("rf_rs1[%0d]", i), {27'd0, bus.rf_rs1},
                {27'd0, vecs[i].rs1});
            if (vecs[i].v && vecs[i].rdy)
                push(vecs[i].e1, vecs[i].e2, vecs[i].rd, vecs[i].w);
            if (vecs[i].v && !vecs[i].rdy)
                exp_stalls++;
            next();
        end
        set_wb(0, 0, 0);

        // Backpressure: hold A for three cycles, then A/B back to back.
        bus.out_ready = 1'b0;
        set_in(1, 3, 4, 10, 0, 'hA1, 'hA2);
        @(negedge clk);
        chk("bp_accept_a", {31'd0, bus.in_ready}, 32'd1);
        push('hA1, 'hA2, 10, 0);
        next();
        set_in(1, 1, 2, 11, 1, 'hB1, 'hB2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("bp_hold_rv1", bus.out_rv1, 32'hA1);
            chk("bp_hold_rv2", bus.out_rv2, 32'hA2);
            next();
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept_b", {31'd0, bus.in_ready}, 32'd1);
        push('hB1, 'hB2, 11, 1);
        next();
        set_in(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("bp_b2b_valid", {31'd0, bus.out_valid}, 32'd1);
        next();
        set_wb(1, 11, 0);
        next();
        set_wb(0, 0, 0);

        // Flush of a held writer releases its scoreboard entry.
        bus.out_ready = 1'b0;
        set_in(1, 0, 0, 7, 1, 0, 0);
        @(negedge clk);
        chk("fl_accept", {31'd0, bus.in_ready}, 32'd1);
        push(0, 0, 7, 1);
        next();
        set_in(1, 7, 0, 12, 0, 'h71, 0);
        bus.flush = 1'b1;
        @(negedge clk);
        chk("fl_no_accept", {31'd0, bus.in_ready}, 32'd0);
        exp_stalls++;
        next();
        bus.flush = 1'b0;
        @(negedge clk);
        chk("fl_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("fl_rs1_ready", {31'd0, bus.in_ready}, 32'd1);
        push('h71, 0, 12, 0);
        next();
        set_in(0, 0, 0, 0, 0, 0, 0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("fl_after_valid", {31'd0, bus.out_valid}, 32'd1);
        next();

`ifdef OPFETCH_STALL_COUNTER_EN
        chk("stall_count", bus.stall_count, exp_stalls);
`else
        chk("stall_count", bus.stall_count, 32'd0);
`endif

        // Asynchronous reset while a writer is held.
        bus.out_ready = 1'b0;
        set_in(1, 0, 0, 13, 1, 0, 0);
        next();
        set_in(0, 0, 0, 0, 0, 0, 0);
        chk("ar_held", {31'd0, bus.out_valid}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("ar_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("ar_stall_count", bus.stall_count, 32'd0);
        rst = 1'b0;
        q.delete();
        bus.out_ready = 1'b1;
        set_in(1, 13, 0, 14, 0, 'h31, 0);
        @(negedge clk);
        chk("ar_busy_cleared", {31'd0, bus.in_ready}, 32'd1);
        push('h31, 0, 14, 0);
        next();
        set_in(0, 0, 0, 0, 0, 0, 0);
        next();
        next();

        chk("queue_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
